// File: rtl/apb_slave_regbank.sv
`default_nettype none
// ============================================================================
// Module      : apb_slave_regbank
// Description : APB4 completer holding NUM_REGS read/write registers with
//               programmable wait states, byte strobes, pprot write
//               protection and pslverr. Register contents and per-register
//               write pulses are exported to the hardware side.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_slave_regbank #(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter int                 NUM_REGS    = 8,
  parameter int                 WAIT_CYCLES = 0,
  parameter int                 PROT_CHECK  = 1,
  parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [2:0]                 pprot,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W/8-1:0]        pstrb,
  output logic                       pready,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = ADDR_W - LSB;
  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] c_wait_max = CNT_W'(WAIT_CYCLES);
  localparam logic [IDX_W:0]   c_num_regs = (IDX_W + 1)'(NUM_REGS);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_setup  = 2'd1;
  localparam logic [1:0] c_access = 2'd2;

  // r_state holds the bus phase seen in the previous cycle; w_phase is the
  // phase of the current cycle, derived from it and the live psel/penable.
  logic [1:0]        r_state;
  logic [1:0]        w_phase;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_ready;
  logic              w_err;
  logic              w_misalign;
  logic              w_in_range;
  logic              w_prot_err;
  logic              w_we;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_mux;
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic              w_unused;

  // pprot[2:1] carry no meaning for this bank
  assign w_unused = &{1'b0, pprot};

  // Address decode
  assign w_idx      = paddr[ADDR_W-1:LSB];
  assign w_in_range = ({1'b0, w_idx} < c_num_regs);
  assign w_prot_err = (PROT_CHECK != 0) && pwrite && !pprot[0];

  generate
    if (LSB > 0) begin : g_align
      assign w_misalign = |paddr[LSB-1:0];
    end else begin : g_no_align
      assign w_misalign = 1'b0;
    end
  endgenerate

  assign w_err   = !w_in_range || w_misalign || w_prot_err;
  assign w_ready = (w_phase == c_access) && psel && penable && (r_cnt == c_wait_max);

  // State register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Current-cycle phase: access only follows a setup or a pending access
  always_comb begin
    w_phase = c_idle;
    if (!psel) begin
      w_phase = c_idle;
    end else if (!penable) begin
      w_phase = c_setup;
    end else if ((r_state == c_setup) || (r_state == c_access)) begin
      w_phase = c_access;
    end else begin
      w_phase = c_idle;
    end
  end

  // Next state: a completed access returns to idle, otherwise track the phase
  always_comb begin
    w_state_nxt = w_phase;
    if ((w_phase == c_access) && w_ready) begin
      w_state_nxt = c_idle;
    end
  end

  // Bus outputs and write enable for the completion cycle
  always_comb begin
    pready  = w_ready;
    pslverr = w_ready && w_err;
    w_we    = w_ready && pwrite && !w_err;
    prdata  = '0;
    if (w_ready && !pwrite && !w_err) begin
      prdata = w_rd_mux;
    end
  end

  // Read mux over the register array
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_rd_mux = r_regs[i];
      end
    end
  end

  // Wait counter: cleared in setup, counts stalled access cycles, saturates
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_cnt <= '0;
    end else if (w_phase == c_setup) begin
      r_cnt <= '0;
    end else if ((w_phase == c_access) && !w_ready && (r_cnt != c_wait_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Register bank with per-byte-lane write strobes
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else if (w_we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_idx == IDX_W'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (pstrb[b]) begin
              r_regs[i][b*8 +: 8] <= pwdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // One-cycle write pulse, raised even for an all-zero strobe
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_we) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_idx == IDX_W'(i)) begin
            r_wr_pulse[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign wr_pulse = r_wr_pulse;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regq
      assign reg_q[gi*DATA_W +: DATA_W] = r_regs[gi];
    end
  endgenerate

endmodule
`default_nettype wire
